// File: rtl/wspr_pkg.sv
// Shared types, default timing constants and the tone-offset helper for the WSPR symbol player.
package wspr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } wspr_state_e;

  typedef logic [31:0] tuning_word_t;

  localparam int SYMBOL_COUNT = 162;
  localparam int BASE_TICKS   = 17066666;
  localparam int FRAC_NUM     = 2;
  localparam int FRAC_DEN     = 3;
  localparam int TICK_W       = 25;

  // sym * step without a multiplier: tones only span 0..3.
  function automatic tuning_word_t tone_offset(input logic [1:0] sym, input tuning_word_t step);
    tuning_word_t twice;
    tuning_word_t once;
    twice = sym[1] ? (step << 1) : '0;
    once  = sym[0] ? step : '0;
    return twice + once;
  endfunction

endpackage

// File: rtl/wspr_symbol_player_if.sv
// Firmware/NCO-facing signal bundle of the WSPR symbol player.
interface wspr_symbol_player_if;
  import wspr_pkg::*;

  // start, abort and ppsTick are single-cycle strobes sampled on the clock edge; the NCO side
  // qualifies tuningWord by watching tuningToggle change rather than by a valid/ready pair.
  logic         symWrEn;
  logic [7:0]   symWrAddr;
  logic [1:0]   symWrData;
  tuning_word_t baseWord;
  tuning_word_t toneStep;
  logic         start;
  logic         abort;
  logic         ppsTick;
  tuning_word_t tuningWord;
  logic         tuningToggle;
  logic         rfEnable;
  logic         busy;
  logic [7:0]   symbolIndex;
  logic         done;
  wspr_state_e  state;

  modport master (
    output symWrEn, symWrAddr, symWrData, baseWord, toneStep, start, abort, ppsTick,
    input  tuningWord, tuningToggle, rfEnable, busy, symbolIndex, done, state
  );

  modport slave (
    input  symWrEn, symWrAddr, symWrData, baseWord, toneStep, start, abort, ppsTick,
    output tuningWord, tuningToggle, rfEnable, busy, symbolIndex, done, state
  );
endinterface

// File: rtl/wspr_symbol_timer.sv
// Symbol period counter with a Bresenham accumulator for the fractional clocks per symbol.
module wspr_symbol_timer #(
  parameter int BASE_TICKS = wspr_pkg::BASE_TICKS,
  parameter int FRAC_NUM   = wspr_pkg::FRAC_NUM,
  parameter int FRAC_DEN   = wspr_pkg::FRAC_DEN,
  parameter int TICK_W     = wspr_pkg::TICK_W
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic run,
  output logic symbolEnd
);
  logic [TICK_W-1:0] cnt_q, cnt_d;
  logic [TICK_W-1:0] last_q, last_d;
  logic [TICK_W-1:0] acc_q, acc_d;
  logic [TICK_W-1:0] acc_sum;
  logic              long_sym;

  // clear starts symbol 0 from an empty accumulator; every symbol end starts the next one.
  always_comb begin
    acc_sum   = (clear ? '0 : acc_q) + TICK_W'(FRAC_NUM);
    long_sym  = (acc_sum >= TICK_W'(FRAC_DEN));
    symbolEnd = run && !clear && (cnt_q == last_q);
    cnt_d     = cnt_q;
    last_d    = last_q;
    acc_d     = acc_q;
    if (clear || symbolEnd) begin
      cnt_d  = '0;
      acc_d  = long_sym ? (acc_sum - TICK_W'(FRAC_DEN)) : acc_sum;
      last_d = long_sym ? TICK_W'(BASE_TICKS) : TICK_W'(BASE_TICKS - 1);
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      cnt_q  <= '0;
      last_q <= '0;
      acc_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      acc_q  <= acc_d;
    end
  end
endmodule

// File: rtl/wspr_symbol_player.sv
// Plays the symbol RAM as NCO tuning words at the WSPR symbol rate and keys the PA meanwhile.
// WSPR_PPS_START_EN: when defined, start arms the block and the next ppsTick begins transmission.
module wspr_symbol_player #(
  parameter int SYMBOL_COUNT = wspr_pkg::SYMBOL_COUNT,
  parameter int BASE_TICKS   = wspr_pkg::BASE_TICKS,
  parameter int FRAC_NUM     = wspr_pkg::FRAC_NUM,
  parameter int FRAC_DEN     = wspr_pkg::FRAC_DEN,
  parameter int TICK_W       = wspr_pkg::TICK_W
) (
  input logic                 clk25MHz,
  input logic                 resetN,
  wspr_symbol_player_if.slave bus
);
  import wspr_pkg::*;

  localparam logic [7:0] LAST_IDX = 8'(SYMBOL_COUNT - 1);

  wspr_state_e  state_q, state_d;
  tuning_word_t base_q, base_d, step_q, step_d;
  logic [7:0]   rd_idx_q, rd_idx_d, idx_p_q, idx_p_d;
  logic         pend_q, pend_d, fin0_q, fin0_d, ld_q, ld_d, fin1_q, fin1_d, tail_q, tail_d;
  tuning_word_t word_q, word_d;
  logic         toggle_q, toggle_d, rf_q, rf_d, done_q, done_d;
  logic [7:0]   idx_q, idx_d;
  logic [1:0]   ram_q;
  logic [1:0]   ram [256];
  logic         enter, tmr_run, sym_end;

  always_ff @(posedge clk25MHz) begin
    if (bus.symWrEn) ram[bus.symWrAddr] <= bus.symWrData;
    ram_q <= ram[rd_idx_q];
  end

  assign tmr_run = (state_q == ST_RUN) && !tail_q;

  wspr_symbol_timer #(
    .BASE_TICKS(BASE_TICKS), .FRAC_NUM(FRAC_NUM), .FRAC_DEN(FRAC_DEN), .TICK_W(TICK_W)
  ) u_timer (
    .clk(clk25MHz), .resetN(resetN), .clear(enter), .run(tmr_run), .symbolEnd(sym_end)
  );

  // rd_idx leads the air by two clocks (RAM read, output register); pend/ld and fin0/fin1
  // carry "new symbol" and "message over" through that same two-stage delay.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    step_d   = step_q;
    rd_idx_d = rd_idx_q;
    idx_p_d  = rd_idx_q;
    pend_d   = 1'b0;
    fin0_d   = 1'b0;
    ld_d     = 1'b0;
    fin1_d   = 1'b0;
    tail_d   = tail_q;
    word_d   = word_q;
    toggle_d = toggle_q;
    rf_d     = rf_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    enter    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.abort && bus.start) begin
`ifdef WSPR_PPS_START_EN
          state_d = ST_ARMED;
`else
          enter = 1'b1;
`endif
        end
      end
`ifdef WSPR_PPS_START_EN
      ST_ARMED: begin
        if (bus.abort)        state_d = ST_IDLE;
        else if (bus.ppsTick) enter   = 1'b1;
      end
`endif
      ST_RUN: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
          word_d  = '0;
          rf_d    = 1'b0;
          idx_d   = '0;
          tail_d  = 1'b0;
          if (word_q != '0) toggle_d = ~toggle_q;
        end else begin
          ld_d   = pend_q;
          fin1_d = fin0_q;
          if (sym_end) begin
            if (rd_idx_q == LAST_IDX) begin
              fin0_d = 1'b1;
              tail_d = 1'b1;
            end else begin
              rd_idx_d = rd_idx_q + 8'd1;
              pend_d   = 1'b1;
            end
          end
          if (fin1_q) begin
            state_d  = ST_IDLE;
            word_d   = '0;
            rf_d     = 1'b0;
            idx_d    = '0;
            done_d   = 1'b1;
            tail_d   = 1'b0;
            toggle_d = ~toggle_q;
          end else if (ld_q) begin
            word_d   = base_q + tone_offset(ram_q, step_q);
            rf_d     = 1'b1;
            idx_d    = idx_p_q;
            toggle_d = ~toggle_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter) begin
      state_d  = ST_RUN;
      base_d   = bus.baseWord;
      step_d   = bus.toneStep;
      rd_idx_d = '0;
      pend_d   = 1'b1;
      tail_d   = 1'b0;
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (!resetN) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      step_q   <= '0;
      rd_idx_q <= '0;
      idx_p_q  <= '0;
      pend_q   <= 1'b0;
      fin0_q   <= 1'b0;
      ld_q     <= 1'b0;
      fin1_q   <= 1'b0;
      tail_q   <= 1'b0;
      word_q   <= '0;
      toggle_q <= 1'b0;
      rf_q     <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      step_q   <= step_d;
      rd_idx_q <= rd_idx_d;
      idx_p_q  <= idx_p_d;
      pend_q   <= pend_d;
      fin0_q   <= fin0_d;
      ld_q     <= ld_d;
      fin1_q   <= fin1_d;
      tail_q   <= tail_d;
      word_q   <= word_d;
      toggle_q <= toggle_d;
      rf_q     <= rf_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign bus.tuningWord   = word_q;
  assign bus.tuningToggle = toggle_q;
  assign bus.rfEnable     = rf_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.symbolIndex  = idx_q;
  assign bus.done         = done_q;
  assign bus.state        = state_q;
endmodule

// File: tb/tb_wspr_symbol_player.sv
// Bench for wspr_symbol_player with a short message (4 symbols, 10 2/3 clocks per symbol).
module tb_wspr_symbol_player;
  localparam int NSYM = 4;
  localparam int BT   = 10;
  localparam int FN   = 2;
  localparam int FD   = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #20 clk = ~clk;

  wspr_symbol_player_if bus();

  wspr_symbol_player #(
    .SYMBOL_COUNT(NSYM), .BASE_TICKS(BT), .FRAC_NUM(FN), .FRAC_DEN(FD), .TICK_W(25)
  ) dut (
    .clk25MHz(clk),
    .resetN(resetN),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [1:0]  sym_m [NSYM];
  logic [31:0] base_m, step_m;
  logic [31:0] exp_q[$];

  // Symbol k lasts BT plus however much floor(k*FN/FD) grows across it.
  function automatic int dur(input int k);
    return BT + ((k + 1) * FN) / FD - (k * FN) / FD;
  endfunction

  function automatic logic [31:0] word_of(input logic [1:0] s);
    return base_m + step_m * {30'd0, s};
  endfunction

  task automatic build_expect();
    exp_q.delete();
    for (int k = 0; k < NSYM; k++) exp_q.push_back(word_of(sym_m[k]));
  endtask

  task automatic load_ram();
    for (int k = 0; k < NSYM; k++) begin
      bus.symWrEn   = 1'b1;
      bus.symWrAddr = 8'(k);
      bus.symWrData = sym_m[k];
      @(negedge clk);
    end
    bus.symWrEn = 1'b0;
  endtask

  task automatic kick();
    bus.baseWord = base_m;
    bus.toneStep = step_m;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
`ifdef WSPR_PPS_START_EN
    for (int i = 0; i < 50; i++) begin
      vectors++;
      if (bus.busy !== 1'b1 || bus.rfEnable !== 1'b0 || bus.tuningWord !== 32'd0) begin
        miscompares++;
        $display("FAIL armed i=%0d: busy=%b rf=%b word=%h, want busy=1 rf=0 word=0",
                 i, bus.busy, bus.rfEnable, bus.tuningWord);
      end
      @(negedge clk);
    end
    bus.ppsTick = 1'b1;
    @(negedge clk);
    bus.ppsTick = 1'b0;
`endif
  endtask

  // Starts the loaded message and checks every cycle against the model; negative
  // arguments disable the optional abort / reset / restart / late-write events.
  task automatic play_message(input int abort_s, input int reset_s, input int restart_s, input int wr_s);
    int st [NSYM+1];
    int s_end, stop, k, flips, exp_flips;
    bit halted;
    logic prev_tog, ebusy, erf, edone;
    logic [31:0] ew;
    logic [7:0] ei;
    st[0] = 2;
    for (int j = 0; j < NSYM; j++) st[j+1] = st[j] + dur(j);
    s_end = st[NSYM];
    build_expect();
    kick();
    prev_tog  = bus.tuningToggle;
    flips     = 0;
    exp_flips = NSYM + 1;
    halted    = 1'b0;
    stop      = s_end + 3;
    for (int s = 0; s <= stop; s++) begin
      k = 0;
      for (int j = 0; j < NSYM; j++) if (s >= st[j]) k = j;
      erf   = (s >= st[0]) && (s < s_end);
      ew    = erf ? exp_q[k] : 32'd0;
      ei    = erf ? 8'(k) : 8'd0;
      ebusy = (s < s_end);
      edone = (s == s_end);
      if (halted) begin
        erf = 1'b0; ew = 32'd0; ei = 8'd0; ebusy = 1'b0; edone = 1'b0;
      end
      vectors++;
      if (bus.tuningWord !== ew || bus.rfEnable !== erf || bus.symbolIndex !== ei ||
          bus.busy !== ebusy || bus.done !== edone) begin
        miscompares++;
        $display("FAIL play s=%0d: word=%h rf=%b idx=%0d busy=%b done=%b, want word=%h rf=%b idx=%0d busy=%b done=%b",
                 s, bus.tuningWord, bus.rfEnable, bus.symbolIndex, bus.busy, bus.done,
                 ew, erf, ei, ebusy, edone);
      end
      if (bus.tuningToggle !== prev_tog) flips++;
      prev_tog = bus.tuningToggle;
      if (reset_s >= 0 && s == reset_s + 1) begin
        vectors++;
        if (bus.tuningToggle !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_toggle: toggle=%b, want 0", bus.tuningToggle);
        end
        resetN = 1'b1;
      end
      if (s == abort_s) begin
        bus.abort = 1'b1;
        exp_flips = flips + ((ew != 32'd0) ? 1 : 0);
        halted    = 1'b1;
        stop      = s + 4;
      end
      if (s == reset_s) begin
        resetN = 1'b0;
        halted = 1'b1;
        stop   = s + 4;
      end
      if (s == 5) begin
        bus.baseWord = $urandom;
        bus.toneStep = $urandom;
      end
      if (s == restart_s) bus.start = 1'b1;
      if (s == wr_s) begin
        sym_m[NSYM-1]   = ~sym_m[NSYM-1];
        exp_q[NSYM-1]   = word_of(sym_m[NSYM-1]);
        bus.symWrEn     = 1'b1;
        bus.symWrAddr   = 8'(NSYM - 1);
        bus.symWrData   = sym_m[NSYM-1];
      end
      @(negedge clk);
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.symWrEn = 1'b0;
    end
    if (reset_s < 0) begin
      vectors++;
      if (flips !== exp_flips) begin
        miscompares++;
        $display("FAIL toggle_count: flips=%0d, want %0d", flips, exp_flips);
      end
    end
  endtask

  task automatic check_idle(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      vectors++;
      if (bus.busy !== 1'b0 || bus.rfEnable !== 1'b0 || bus.tuningWord !== 32'd0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s i=%0d: busy=%b rf=%b word=%h done=%b, want all 0",
                 name, i, bus.busy, bus.rfEnable, bus.tuningWord, bus.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.tuningWord !== 32'd0 || bus.tuningToggle !== 1'b0 || bus.rfEnable !== 1'b0 ||
        bus.busy !== 1'b0 || bus.symbolIndex !== 8'd0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: word=%h tog=%b rf=%b busy=%b idx=%0d done=%b, want all 0",
               bus.tuningWord, bus.tuningToggle, bus.rfEnable, bus.busy, bus.symbolIndex, bus.done);
    end
    resetN = 1'b1;
    @(negedge clk);
    check_idle("post_reset", 2);
  endtask

  task automatic test_pps_idle();
    bus.ppsTick = 1'b1;
    @(negedge clk);
    bus.ppsTick = 1'b0;
    check_idle("pps_idle", 3);
  endtask

  task automatic test_start_abort_same();
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_idle("start_abort", 3);
  endtask

`ifdef WSPR_PPS_START_EN
  task automatic test_armed_abort();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL armed_busy: busy=%b, want 1", bus.busy);
    end
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort   = 1'b0;
    bus.ppsTick = 1'b1;
    @(negedge clk);
    bus.ppsTick = 1'b0;
    check_idle("armed_abort", 4);
  endtask
`endif

  task automatic test_directed();
    sym_m  = '{2'd0, 2'd1, 2'd2, 2'd3};
    base_m = 32'd1000;
    step_m = 32'd31;
    load_ram();
    play_message(-1, -1, -1, -1);
  endtask

  task automatic test_wrap();
    sym_m  = '{2'd3, 2'd0, 2'd1, 2'd3};
    base_m = 32'hFFFF_FFF0;
    step_m = 32'h10;
    load_ram();
    play_message(-1, -1, -1, -1);
  endtask

  task automatic test_abort_replay();
    sym_m  = '{2'd0, 2'd1, 2'd2, 2'd3};
    base_m = 32'd1000;
    step_m = 32'd31;
    load_ram();
    play_message(26, -1, -1, -1);
    play_message(-1, -1, -1, -1);
  endtask

  task automatic test_restart_ignored();
    play_message(-1, -1, 15, -1);
  endtask

  task automatic test_late_write();
    play_message(-1, -1, -1, 5);
  endtask

  task automatic test_reset_mid_run();
    sym_m  = '{2'd2, 2'd3, 2'd1, 2'd0};
    base_m = 32'h1234_5678;
    step_m = 32'h0000_0100;
    load_ram();
    play_message(-1, 20, -1, -1);
    play_message(-1, -1, -1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NSYM; k++) sym_m[k] = 2'($urandom_range(0, 3));
      base_m = $urandom;
      step_m = $urandom;
      load_ram();
      play_message(-1, -1, -1, -1);
    end
  endtask

  initial begin
    bus.symWrEn   = 1'b0;
    bus.symWrAddr = 8'd0;
    bus.symWrData = 2'd0;
    bus.baseWord  = 32'd0;
    bus.toneStep  = 32'd0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.ppsTick   = 1'b0;
    @(negedge clk);
    test_reset();
    test_pps_idle();
    test_start_abort_same();
`ifdef WSPR_PPS_START_EN
    test_armed_abort();
`endif
    test_directed();
    test_wrap();
    test_abort_replay();
    test_restart_ignored();
    test_late_write();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
